nibble_serial_add_seq: RTL and testbench

NIBBLE_SERIAL_ADD_SEQ -- requirements
Module: nibble_serial_add_seq

---
 rtl/nibble_serial_add_seq.sv | 119 +++++++++++
 tb/tb_nibble_serial_add_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// Multi-cycle adder that walks W = 4*NIBBLES-bit operands one nibble per cycle
// through an external 4-bit fast-carry adder, rippling the carry through a register.
module nibble_serial_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic [3:0]           nib_a,
    output logic [3:0]           nib_b,
    output logic                 nib_cin,
    input  logic [3:0]           nib_sum,
    input  logic                 nib_cout,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [NIBBLES-1:0][3:0]     a_q, a_d;
    logic [NIBBLES-1:0][3:0]     b_q, b_d;
    logic [NIBBLES-1:0][3:0]     sum_q, sum_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic                        cout_q, cout_d;
    logic                        ovf_q, ovf_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, datapath update and external-adder drive
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        nib_a   = 4'h0;
        nib_b   = 4'h0;
        nib_cin = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    carry_d = cin;
                end
            end
            RUN: begin
                nib_a        = a_q[idx_q];
                nib_b        = b_q[idx_q];
                nib_cin      = carry_q;
                sum_d[idx_q] = nib_sum;
                carry_d      = nib_cout;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = nib_cout;
                    // Signed overflow: like-signed operands yielding an opposite-signed result
                    ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                              (nib_sum[3] != a_q[NIBBLES-1][3]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Randomized self-checking bench for nibble_serial_add_seq against a whole-word arithmetic model.
module tb_nibble_serial_add_seq;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic [3:0]   nib_a, nib_b, nib_sum;
    logic         nib_cin, nib_cout;
    logic [W-1:0] sum;
    logic         cout, ovf, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External 4-bit adder
    assign {nib_cout, nib_sum} = 5'(nib_a) + 5'(nib_b) + 5'(nib_cin);

    nibble_serial_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .nib_a   (nib_a),
        .nib_b   (nib_b),
        .nib_cin (nib_cin),
        .nib_sum (nib_sum),
        .nib_cout(nib_cout),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full addition; hold=1 keeps start asserted with other operands throughout the run
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input bit hold);
        longint unsigned full, mask, cin_k;
        logic [W-1:0]    exp_sum;
        logic            exp_cout, exp_ovf;
        int              lat;
        full     = longint'(a) + longint'(b) + longint'(c);
        exp_sum  = W'(full);
        exp_cout = full[W];
        exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

        start = 1'b1; op_a = a; op_b = b; cin = c;
        tick();
        if (hold) begin
            op_a = 16'hAAAA; op_b = 16'h1111; cin = 1'b1;
        end else begin
            start = 1'b0;
        end
        lat = 0;
        while (!done && lat < 3 * NIBBLES) begin
            check("busy_run", 64'(busy), 64'd1);
            if (lat < NIBBLES) begin
                mask  = (64'd1 << (4 * lat)) - 64'd1;
                cin_k = (((longint'(a) & mask) + (longint'(b) & mask) + longint'(c)) >> (4 * lat)) & 64'd1;
                check("nib_a", 64'(nib_a), (longint'(a) >> (4 * lat)) & 64'hF);
                check("nib_b", 64'(nib_b), (longint'(b) >> (4 * lat)) & 64'hF);
                check("nib_cin", 64'(nib_cin), cin_k);
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(NIBBLES));
        check("sum", 64'(sum), 64'(exp_sum));
        check("cout", 64'(cout), 64'(exp_cout));
        check("ovf", 64'(ovf), 64'(exp_ovf));
        check("busy_done", 64'(busy), 64'd1);
        check("nib_a_done", 64'(nib_a), 64'd0);
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("sum_hold", 64'(sum), 64'(exp_sum));
        check("cout_hold", 64'(cout), 64'(exp_cout));
        check("nib_cin_idle", 64'(nib_cin), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
        tick();
        tick();
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_nib_a", 64'(nib_a), 64'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        run_add(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_add(16'h0001, 16'h0001, 1'b0, 1'b1);

        // Reset during RUN with idx=2
        start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_nib_a", 64'(nib_a), 64'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_nib_cin", 64'(nib_cin), 64'd0);
        for (int i = 0; i < 2 * NIBBLES; i++) begin
            check("abort_no_done", 64'(done), 64'd0);
            tick();
        end
        run_add(16'h0F0F, 16'h00F1, 1'b1, 1'b0);

        // Random back-to-back operations
        for (int i = 0; i < 40; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
